// File: rtl/mips_if_pkg.sv
// Shared constants and types for the MIPS instruction-fetch queue.
// Counter widths hold 0..QUEUE_DEPTH inclusive, hence the extra bit.
package mips_if_pkg;
    localparam int INSTR_BYTES    = 4;
    localparam int IF_ADDR_W      = 32;
    localparam int IF_DATA_W      = 32;
    localparam int IF_QUEUE_DEPTH = 4;
    localparam int IF_CNT_W       = $clog2(IF_QUEUE_DEPTH) + 1;
    localparam logic [IF_ADDR_W-1:0] PC_ALIGN_MASK = ~IF_ADDR_W'(INSTR_BYTES - 1);

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [IF_DATA_W-1:0] instruction;
        logic [IF_ADDR_W-1:0] pc;
    } if_entry_t;
endpackage

// File: rtl/if_sync_fifo.sv
// First-word fall-through synchronous FIFO with a synchronous flush.
// Head data is combinational from storage; a push is visible the next cycle.
module if_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Push into a full FIFO is legal only together with a pop of the head.
    assign do_pop  = pop & (count_q != '0) & ~flush;
    assign do_push = push & ~flush & ((count_q != CW'(DEPTH)) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/if_fetch_queue.sv
// MIPS fetch stage: credit-limited prefetch into a FWFT queue, with redirects
// flushing the queue and dropping responses of requests already in flight.
module if_fetch_queue
    import mips_if_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = 32,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  control_is_jump,
    input  logic                  control_branch_eq,
    input  logic                  control_branch_inc,
    input  logic                  control_is_zero,
    input  logic [ADDR_WIDTH-1:0] data_jump_address,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_rvalid,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc
);
    localparam int CW = cnt_width(QUEUE_DEPTH);
    localparam int EW = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(INSTR_BYTES - 1);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         out_q, out_d, drop_q, drop_d;
    logic [CW-1:0]         q_count, tag_count;
    logic [CW:0]           credit_used;
    logic [EW-1:0]         q_head;
    logic [ADDR_WIDTH-1:0] tag_head;
    logic                  redirect, issue, rv_ok, rv_keep, pop;

    assign redirect = control_is_jump
                    | (control_branch_eq  &  control_is_zero)
                    | (control_branch_inc & ~control_is_zero);

    // Credit: queued words plus outstanding requests never exceed the depth.
    assign credit_used = {1'b0, q_count} + {1'b0, out_q};
    assign issue   = reset & ~redirect & (credit_used < (CW+1)'(QUEUE_DEPTH));
    assign rv_ok   = imem_rvalid & (out_q != '0);
    assign rv_keep = rv_ok & (drop_q == '0) & ~redirect & (tag_count != '0);
    assign pop     = instr_valid & instr_ready & ~redirect;

    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q + CW'(issue) - CW'(rv_ok);
        drop_d = drop_q;
        if (redirect) begin
            pc_d   = data_jump_address & ALIGN;
            drop_d = out_q - CW'(rv_ok);
        end else begin
            if (issue) pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
            if (rv_ok && drop_q != '0) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    // Request PCs in issue order; popped only by responses that are kept.
    if_sync_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(ADDR_WIDTH)) u_tag_fifo (
        .clk   (clock),
        .rst_n (reset),
        .flush (redirect),
        .push  (issue),
        .wdata (pc_q),
        .pop   (rv_keep),
        .rdata (tag_head),
        .count (tag_count)
    );

    if_sync_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(EW)) u_instr_fifo (
        .clk   (clock),
        .rst_n (reset),
        .flush (redirect),
        .push  (rv_keep),
        .wdata ({imem_rdata, tag_head}),
        .pop   (pop),
        .rdata (q_head),
        .count (q_count)
    );

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign instr_valid = (q_count != '0);
    assign instruction = instr_valid ? q_head[EW-1:ADDR_WIDTH] : '0;
    assign instr_pc    = instr_valid ? q_head[ADDR_WIDTH-1:0]  : '0;
endmodule
